id_ex_operand_stage: RTL and testbench

Operand-fetch and issue stage that sits directly upstream of the 64-bit ALU. It holds the 32×64 register file and sign-extends the immediate. A pending-write scoreboard stalls on RAW and WAW hazards. Issued operations go into a single-entry ID/EX pipeline register whose outputs drive the ALU's src1_i, src2_i and ctrl_i.

---
 rtl/id_ex_operand_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// Operand fetch and issue stage in front of the 64-bit ALU. It holds the register
// file, a busy-bit scoreboard for RAW/WAW stalls and a single-entry ID/EX register.
module id_ex_operand_stage #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic              alu_src_i,
  input  logic [3:0]        alu_ctrl_i,
  input  logic              reg_write_i,
  input  logic              wb_en_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        ctrl_o,
  output logic [4:0]        dest_o,
  output logic              wen_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [4:0]        dest_q, dest_d;
  logic              wen_q, wen_d;

  logic              rs_byp_s, rt_byp_s;
  logic [DATA_W-1:0] rs_val_s, rt_val_s, imm_ext_s;
  logic              haz_s, ready_s, accept_s;

  // Operand read with write-through bypass of the current write-back.
  always_comb begin
    rs_byp_s  = wb_en_i && (wb_addr_i == rs_i);
    rt_byp_s  = wb_en_i && (wb_addr_i == rt_i);
    imm_ext_s = {{(DATA_W-16){imm_i[15]}}, imm_i};
    if (rs_i == 5'd0) begin
      rs_val_s = '0;
    end else if (rs_byp_s) begin
      rs_val_s = wb_data_i;
    end else begin
      rs_val_s = regs_q[rs_i];
    end
    if (rt_i == 5'd0) begin
      rt_val_s = '0;
    end else if (rt_byp_s) begin
      rt_val_s = wb_data_i;
    end else begin
      rt_val_s = regs_q[rt_i];
    end
  end

  // The WAW term is deliberately not exempted by a same-cycle write-back.
  always_comb begin
    haz_s    = in_valid_i &&
               ((busy_q[rs_i] && !rs_byp_s) ||
                (busy_q[rt_i] && !alu_src_i && !rt_byp_s) ||
                (reg_write_i && busy_q[rd_i]));
    ready_s  = !haz_s && (!valid_q || out_ready_i) && !flush_i;
    accept_s = in_valid_i && ready_s;
  end

  // Scoreboard next state: write-back and flush clear, a new accept sets last.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) begin
      busy_d[wb_addr_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (flush_i && valid_q && wen_q) begin
      busy_d[dest_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (accept_s && reg_write_i && (rd_i != 5'd0)) begin
      busy_d[rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // ID/EX register next state; flush and accept never coincide.
  always_comb begin
    valid_d = valid_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    wen_d   = wen_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      src1_d  = rs_val_s;
      src2_d  = alu_src_i ? imm_ext_s : rt_val_s;
      ctrl_d  = alu_ctrl_i;
      dest_d  = rd_i;
      wen_d   = reg_write_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register and scoreboard state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctrl_q  <= 4'd0;
      dest_q  <= 5'd0;
      wen_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      wen_q   <= wen_d;
    end
  end

  // Register file; register 0 is never written and stays zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end else begin
      regs_q[0] <= '0;
    end
  end

  assign in_ready_o  = ready_s;
  assign out_valid_o = valid_q;
  assign src1_o      = src1_q;
  assign src2_o      = src2_q;
  assign ctrl_o      = ctrl_q;
  assign dest_o      = dest_q;
  assign wen_o       = wen_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, alu_src, reg_write, wb_en, flush;
  logic        out_valid, out_ready, wen;
  logic [4:0]  rs, rt, rd, wb_addr, dest;
  logic [15:0] imm;
  logic [3:0]  alu_ctrl, ctrl;
  logic [63:0] wb_data, src1, src2;

  id_ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .alu_src_i(alu_src),
    .alu_ctrl_i(alu_ctrl), .reg_write_i(reg_write), .wb_en_i(wb_en),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .src1_o(src1),
    .src2_o(src2), .ctrl_o(ctrl), .dest_o(dest), .wen_o(wen)
  );

  always #5 clk = ~clk;

  // Model state: architectural registers, pending writers, the one queued op.
  logic [63:0] m_reg [32];
  bit          m_pending [32];
  bit          m_v, m_wen, m_acc, m_rdy, last_ready;
  logic [63:0] m_s1, m_s2;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_dest;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] value_of(input logic [4:0] r);
    if (r == 0) return 64'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic bit model_ready();
    bit blocked;
    blocked = 0;
    if (m_pending[rs] && !(wb_en && wb_addr == rs)) blocked = 1;
    if (!alu_src && m_pending[rt] && !(wb_en && wb_addr == rt)) blocked = 1;
    if (reg_write && m_pending[rd]) blocked = 1;
    if (!in_valid) blocked = 0;
    return !blocked && (!m_v || out_ready) && !flush;
  endfunction

  task automatic model_update();
    bit acc;
    acc = in_valid && model_ready();
    m_acc = acc && !rst;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 64'd0;
        m_pending[i] = 0;
      end
      m_v = 0; m_s1 = 64'd0; m_s2 = 64'd0; m_ctrl = 4'd0; m_dest = 5'd0; m_wen = 0;
    end else begin
      if (acc) begin
        m_s1   = value_of(rs);
        m_s2   = alu_src ? 64'(signed'(imm)) : value_of(rt);
        m_ctrl = alu_ctrl;
      end
      if (wb_en) m_pending[wb_addr] = 0;
      if (flush && m_v && m_wen) m_pending[m_dest] = 0;
      if (acc && reg_write && rd != 0) m_pending[rd] = 1;
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (flush) m_v = 0;
      else if (acc) begin
        m_v = 1; m_dest = rd; m_wen = reg_write;
      end else if (out_ready) m_v = 0;
    end
  endtask

  // One clock: check the combinational ready, advance, check registered outputs.
  task automatic cycle();
    #1;
    m_rdy = model_ready();
    last_ready = in_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    @(posedge clk);
    model_update();
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_v});
    if (m_v) begin
      chk("src1", src1, m_s1);
      chk("src2", src2, m_s2);
      chk("ctrl", {60'd0, ctrl}, {60'd0, m_ctrl});
      chk("dest", {59'd0, dest}, {59'd0, m_dest});
      chk("wen", {63'd0, wen}, {63'd0, m_wen});
    end
  endtask

  task automatic set_op(input bit v, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input bit asrc,
                        input logic [3:0] c, input bit rw);
    in_valid = v; rs = s; rt = t; rd = d; imm = im; alu_src = asrc;
    alu_ctrl = c; reg_write = rw;
  endtask

  initial begin
    bit hold;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
    set_op(0, 5'd0, 5'd0, 5'd0, 16'd0, 0, 4'd0, 0);
    @(posedge clk);
    model_update();
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_src1", src1, 64'd0);
    chk("rst_src2", src2, 64'd0);
    chk("rst_ctrl_dest_wen", {55'd0, ctrl, dest, wen}, 64'd0);
    rst = 1'b0;

    // Write-back then sign-extended immediate issue.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h7;
    cycle();
    wb_en = 1'b0;
    set_op(1, 5'd5, 5'd0, 5'd0, 16'hFFF0, 1, 4'h2, 0);
    cycle();
    chk("imm_src1", src1, 64'h7);
    chk("imm_src2", src2, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("imm_ctrl", {60'd0, ctrl}, 64'h2);

    // RAW stall released by a same-cycle write-back through the bypass.
    set_op(1, 5'd0, 5'd0, 5'd3, 16'd0, 1, 4'h0, 1);
    cycle();
    set_op(1, 5'd3, 5'd0, 5'd0, 16'd0, 1, 4'h0, 0);
    cycle();
    chk("raw_stall", {63'd0, last_ready}, 64'd0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
    cycle();
    chk("raw_release", {63'd0, last_ready}, 64'd1);
    chk("raw_bypass", src1, 64'h1234);

    // Register 0 ignores writes and never becomes busy.
    wb_addr = 5'd0; wb_data = 64'hFF;
    set_op(1, 5'd0, 5'd0, 5'd0, 16'd0, 1, 4'h1, 1);
    cycle();
    wb_en = 1'b0;
    cycle();
    chk("r0_ready", {63'd0, last_ready}, 64'd1);
    chk("r0_src1", src1, 64'd0);

    // Backpressure for three cycles, then takeover in the release cycle.
    set_op(1, 5'd5, 5'd0, 5'd0, 16'h0001, 1, 4'h5, 0);
    cycle();
    out_ready = 1'b0;
    set_op(1, 5'd0, 5'd0, 5'd0, 16'h0002, 1, 4'h6, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", {63'd0, last_ready}, 64'd0);
      chk("bp_hold", {src1[31:0], src2[27:0], ctrl}, {32'd7, 28'd1, 4'h5});
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release", {63'd0, last_ready}, 64'd1);
    chk("bp_take", {src2[59:0], ctrl}, {60'd2, 4'h6});

    // Flush discards a writer and clears its pending bit.
    set_op(1, 5'd0, 5'd0, 5'd4, 16'd0, 1, 4'h1, 1);
    cycle();
    out_ready = 1'b0; flush = 1'b1;
    set_op(0, 5'd0, 5'd0, 5'd0, 16'd0, 1, 4'h0, 0);
    cycle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; out_ready = 1'b1;
    set_op(1, 5'd4, 5'd0, 5'd0, 16'd0, 1, 4'h3, 0);
    cycle();
    chk("flush_noStall", {63'd0, last_ready}, 64'd1);

    // Reset in the middle of a stall.
    set_op(1, 5'd0, 5'd0, 5'd6, 16'd0, 1, 4'h1, 1);
    cycle();
    set_op(1, 5'd6, 5'd0, 5'd0, 16'd0, 1, 4'h1, 0);
    cycle();
    chk("pre_rst_stall", {63'd0, last_ready}, 64'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_out", {src1[31:0], src2[31:0]}, 64'd0);
    chk("mid_rst_ctl", {57'd0, out_valid, ctrl, wen, 1'b0}, 64'd0);
    cycle();
    chk("post_rst_ready", {63'd0, last_ready}, 64'd1);
    set_op(1, 5'd5, 5'd0, 5'd0, 16'd0, 1, 4'h0, 0);
    cycle();
    chk("post_rst_r5", src1, 64'd0);

    // Randomized traffic; a stalled instruction is kept on the inputs.
    for (int n = 0; n < 4000; n++) begin
      hold = in_valid && !m_acc && !rst;
      if (!hold) begin
        set_op($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               16'($urandom), $urandom_range(0, 1) == 1, 4'($urandom),
               $urandom_range(0, 2) != 0);
      end
      wb_en     = $urandom_range(0, 2) == 0;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
      rst       = $urandom_range(0, 299) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
